decode_serial_splitter: RTL and testbench

- Sits between the decoder's output group register and the rename pipeline register.
- Guarantees rename never receives a serialized op outside lane 0, nor a serialized op sharing a group with any other op.
- Buffers one decoded group and emits it as one or more compacted sub-groups.
- Back-pressures upstream while a split is in progress.

---
 rtl/decode_serial_splitter.sv | 121 ++++++++++++
 tb/tb_decode_serial_splitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_serial_splitter.sv
// Buffers one decoded group and replays it to rename as compacted sub-groups.
// Each serialized op is isolated in lane 0; all other op runs stay packed together.
module decode_serial_splitter #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      in_valid,
    input  logic [WIDTH-1:0]      in_serialized,
    input  logic [WIDTH*OP_W-1:0] in_op,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_valid,
    output logic [WIDTH-1:0]      out_serialized,
    output logic [WIDTH*OP_W-1:0] out_op,
    output logic                  busy,
    output logic [CNT_W-1:0]      split_count
);

    localparam int IW = $clog2(WIDTH);
    localparam int HW = IW + 1;

    logic [WIDTH-1:0] buf_valid;
    logic [WIDTH-1:0] buf_ser;
    logic [OP_W-1:0]  buf_op [WIDTH];
    logic [HW-1:0]    head;
    logic [HW-1:0]    n;
    logic [HW-1:0]    sel_end;
    logic [HW-1:0]    span;
    logic             last;
    logic             accept;
    logic             in_split;

    always_comb begin
        n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + HW'(buf_valid[i]);
    end

    assign busy = head < n;

    // A serialized head goes out alone; otherwise stop just before the next serialized op.
    always_comb begin
        sel_end = n;
        if (busy && buf_ser[IW'(head)]) begin
            sel_end = head + HW'(1);
        end else begin
            for (int j = WIDTH - 1; j > 0; j--) begin
                if (HW'(j) > head && buf_ser[j] && buf_valid[j]) sel_end = HW'(j);
            end
        end
    end

    assign last     = busy && (sel_end == n);
    assign in_ready = !clear && !stall && (!busy || last);
    assign accept   = (|in_valid) && in_ready;

    // With contiguous valids, a group splits exactly when it has a serialized op and another op.
    assign in_split = (|(in_serialized & in_valid)) && in_valid[1];

    always_comb begin
        out_valid      = '0;
        out_serialized = '0;
        out_op         = '0;
        span           = sel_end - head;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy && HW'(k) < span) begin
                out_valid[k]               = 1'b1;
                out_serialized[k]          = buf_ser[IW'(head + HW'(k))];
                out_op[k*OP_W +: OP_W]     = buf_op[IW'(head + HW'(k))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid   <= '0;
            buf_ser     <= '0;
            head        <= '0;
            split_count <= '0;
        end else if (clear) begin
            buf_valid <= '0;
            head      <= '0;
        end else if (accept) begin
            buf_valid <= in_valid;
            buf_ser   <= in_serialized & in_valid;
            head      <= '0;
            if (in_split && split_count != '1) split_count <= split_count + CNT_W'(1);
        end else if (busy && !stall) begin
            if (last) begin
                buf_valid <= '0;
                head      <= '0;
            end else begin
                head <= sel_end;
            end
        end
    end

    // NOTE: payload storage is qualified by buf_valid, so it needs no reset and stays plain flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) buf_op[i] <= in_op[i*OP_W +: OP_W];
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ((in_valid & (in_valid + WIDTH'(1))) == '0)
                else $error("in_valid not contiguous: %b", in_valid);
            assert (out_serialized[WIDTH-1:1] == '0)
                else $error("serialized op outside lane 0: %b", out_serialized);
            assert (!(out_serialized[0] && out_valid[1]))
                else $error("serialized op shares its sub-group: %b", out_valid);
        end
    end
`endif

endmodule

// File: tb/tb_decode_serial_splitter.sv
// Self-checking bench: directed test-plan steps plus random groups against a sub-group queue model.
module tb_decode_serial_splitter;

    localparam int W     = 4;
    localparam int OP_W  = 32;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              clear;
    logic [W-1:0]      in_valid;
    logic [W-1:0]      in_serialized;
    logic [W*OP_W-1:0] in_op;
    logic              in_ready;
    logic [W-1:0]      out_valid;
    logic [W-1:0]      out_serialized;
    logic [W*OP_W-1:0] out_op;
    logic              busy;
    logic [CNT_W-1:0]  split_count;

    decode_serial_splitter #(.WIDTH(W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_serialized (in_serialized),
        .in_op         (in_op),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_serialized(out_serialized),
        .out_op        (out_op),
        .busy          (busy),
        .split_count   (split_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]      v;
        logic [W-1:0]      s;
        logic [W*OP_W-1:0] op;
    } sub_t;

    sub_t             exp_q[$];
    logic [CNT_W-1:0] exp_split;
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each serialized op is its own sub-group, each run of plain ops is one packed sub-group.
    task automatic load_group(input logic [W-1:0] v, input logic [W-1:0] s, input logic [W*OP_W-1:0] op);
        sub_t cur;
        int   k;
        int   cnt;
        cur = '0;
        k   = 0;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                if (s[i]) begin
                    if (k > 0) begin
                        exp_q.push_back(cur);
                        cnt++;
                        cur = '0;
                        k   = 0;
                    end
                    cur.v[0]         = 1'b1;
                    cur.s[0]         = 1'b1;
                    cur.op[0 +: OP_W] = op[i*OP_W +: OP_W];
                    exp_q.push_back(cur);
                    cnt++;
                    cur = '0;
                end else begin
                    cur.v[k]              = 1'b1;
                    cur.op[k*OP_W +: OP_W] = op[i*OP_W +: OP_W];
                    k++;
                end
            end
        end
        if (k > 0) begin
            exp_q.push_back(cur);
            cnt++;
        end
        if (cnt > 1 && exp_split != '1) exp_split = exp_split + 1'b1;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model, check the counter.
    task automatic cycle(input logic r, input logic st, input logic cl,
                         input logic [W-1:0] v, input logic [W-1:0] s, input logic [W*OP_W-1:0] op);
        sub_t f;
        logic rdy;
        rst           = r;
        stall         = st;
        clear         = cl;
        in_valid      = v;
        in_serialized = s;
        in_op         = op;
        #1;
        f = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("out_valid", out_valid, f.v);
        check("out_serialized", out_serialized, f.s);
        check("out_op", out_op, f.op);
        check("busy", busy, exp_q.size() != 0);
        rdy = !cl && !st && (exp_q.size() <= 1);
        check("in_ready", in_ready, rdy);
        if (r) begin
            exp_q.delete();
            exp_split = '0;
        end else if (cl) begin
            exp_q.delete();
        end else begin
            if (!st && exp_q.size() > 0) void'(exp_q.pop_front());
            if (rdy && (|v)) load_group(v, s, op);
        end
        @(posedge clk);
        #1;
        check("split_count", split_count, exp_split);
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, st, 1'b0, '0, '0, '0);
    endtask

    localparam logic [OP_W-1:0] OP_A = 32'hA000_0001;
    localparam logic [OP_W-1:0] OP_B = 32'hB000_0002;
    localparam logic [OP_W-1:0] OP_C = 32'hC000_0003;
    localparam logic [OP_W-1:0] OP_D = 32'hD000_0004;
    localparam logic [OP_W-1:0] OP_S = 32'h5E00_0005;
    localparam logic [OP_W-1:0] OP_T = 32'h5E00_0006;

    logic [W*OP_W-1:0] g_abcd;
    logic [W*OP_W-1:0] g_ascd;
    logic [W*OP_W-1:0] g_st;
    logic [W*OP_W-1:0] r_op;
    logic [W-1:0]      r_v;
    int                r_n;

    initial begin
        g_abcd = {OP_D, OP_C, OP_B, OP_A};
        g_ascd = {OP_D, OP_C, OP_S, OP_A};
        g_st   = {32'h0, 32'h0, OP_T, OP_S};
        exp_split = '0;

        rst = 1'b1; stall = 1'b0; clear = 1'b0;
        in_valid = '0; in_serialized = '0; in_op = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 4'b0000);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_split_count", split_count, 8'h00);

        // Plain group passes through whole.
        cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, g_abcd);
        check("abcd_valid", out_valid, 4'b1111);
        check("abcd_op", out_op, g_abcd);
        idle(1'b0);

        // {A,S,C,D} splits into {A}, {S}, {C,D}.
        cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, g_ascd);
        check("ascd_1_valid", out_valid, 4'b0001);
        check("ascd_1_op", out_op[OP_W-1:0], OP_A);
        idle(1'b0);
        check("ascd_2_valid", out_valid, 4'b0001);
        check("ascd_2_ser", out_serialized, 4'b0001);
        check("ascd_2_op", out_op[OP_W-1:0], OP_S);
        idle(1'b0);
        check("ascd_3_valid", out_valid, 4'b0011);
        check("ascd_3_op", out_op[2*OP_W-1:0], {OP_D, OP_C});
        idle(1'b0);
        check("ascd_split_count", split_count, 8'h01);

        // Two serialized ops each go out alone.
        cycle(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0011, g_st);
        check("st_1_op", out_op, {96'h0, OP_S});
        idle(1'b0);
        check("st_2_op", out_op, {96'h0, OP_T});
        idle(1'b0);

        // Stall held on the {S} sub-group.
        cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, g_ascd);
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("stall_hold_op", out_op, {96'h0, OP_S});
        end
        idle(1'b0);
        check("stall_after_valid", out_valid, 4'b0011);
        idle(1'b0);

        // Clear while {S} is presented, with a new group offered.
        cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, g_ascd);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000, g_abcd);
        clear = 1'b0;
        in_valid = '0;
        #1;
        check("clear_out_valid", out_valid, 4'b0000);
        check("clear_busy", busy, 1'b0);
        check("clear_in_ready", in_ready, 1'b1);

        // Saturate the split counter with back-to-back split groups.
        for (int i = 0; i < 520; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0010, g_ascd);
        check("split_saturated", split_count, 8'hFF);
        idle(1'b0);

        // Reset in the middle of a split.
        cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, g_ascd);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 4'b0000);
        check("rst_mid_split_count", split_count, 8'h00);

        // Random groups with random stall and occasional clear.
        for (int i = 0; i < 400; i++) begin
            r_n = $urandom_range(0, W);
            r_v = W'((1 << r_n) - 1);
            for (int l = 0; l < W; l++) r_op[l*OP_W +: OP_W] = $urandom;
            cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  r_v, W'($urandom), r_op);
        end
        repeat (6) idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
